ads1256_scan_ctrl: RTL and testbench
====================================

# ads1256_scan_ctrl

Parametrised ADS1256 acquisition controller. It replaces the single hard-coded RDATA transfer with a full multi-channel scan sequencer containing its own SPI mode-1 shift engine. For each enabled channel it programs the input MUX, restarts conversion, waits for DRDY, issues RDATA and returns a tagged 24-bit sample. It sits between the board top level and the ADS1256 PMOD pins.

## Interface
- NUM_CH, 8: channels scanned per pass, AIN0..AIN(NUM_CH-1) vs AINCOM; legal 1..8.
- CLK_DIV, 32: system cycles per SCLK half-period; must be ≥ 2.
- GAP_CYCLES, 400: idle cycles after every transmitted command byte except RDATA (covers t11).
- T6_CYCLES, 700: cycles between the RDATA byte end and the first read SCLK (covers t6).
- DRDY_TIMEOUT, 2_000_000: maximum cycles spent waiting for DRDY low.

- clock_i  input  1  system clock; all logic on its rising edge.
- reset_ni  input  1  synchronous, active-low reset.
- start_i  input  1  one-cycle pulse; starts a scan when idle.
- continuous_i  input  1  when high at scan end, the next scan starts immediately.
- drdy_ni  input  1  ADS1256 DRDY; asynchronous, active low.
- miso_i  input  1  ADS1256 DOUT.
- mosi_o  output  1  ADS1256 DIN.
- sclk_o  output  1  ADS1256 SCLK; idles low.
- cs_no  output  1  ADS1256 CS; active low.
- sample_o  output  24  last sample, raw two's complement, MSB first as received.
- channel_o  output  3  channel tag of sample_o.
- sample_valid_o  output  1  one-cycle pulse when sample_o/channel_o update.
- scan_done_o  output  1  one-cycle pulse after the last channel of a scan.
- busy_o  output  1  high from start acceptance until return to IDLE.
- error_o  output  1  sticky DRDY-timeout flag; cleared on the next accepted start.

## Operation
- drdy_ni passes through a 2-flop synchronizer. All DRDY decisions use the synchronized value.
- States:
  - IDLE → MUX_WAIT on start_i. Sets ch=0, busy_o=1, cs_no=0.
  - MUX_WAIT → MUX_WR when synced DRDY is low.
  - MUX_WR sends 5 bytes: 0x51, 0x00, {1'b0,ch[2:0],4'h8}, 0xFC (SYNC), 0x00 (WAKEUP). Each byte is followed by GAP_CYCLES. Then → CONV_WAIT.
  - CONV_WAIT first waits for synced DRDY high, then for synced DRDY low (a fresh conversion). Then → RDATA.
  - RDATA sends 0x01, then waits T6_CYCLES. Then → READ.
  - READ clocks 24 bits with mosi_o=0. Then → EMIT.
  - EMIT loads sample_o and channel_o=ch and pulses sample_valid_o. If ch<NUM_CH-1: ch+1 → MUX_WAIT. Otherwise it pulses scan_done_o and goes to MUX_WAIT with ch=0 if continuous_i=1, else → IDLE (busy_o=0, cs_no=1).
- SPI shift engine, mode 1, MSB first:
  - Each bit starts by driving mosi_o and raising sclk_o in the same cycle.
  - sclk_o falls CLK_DIV cycles later; miso_i is sampled in that falling-edge cycle.
  - The next bit starts CLK_DIV cycles after the fall.
- Timeout: a counter runs in MUX_WAIT and CONV_WAIT and resets on each state entry. Reaching DRDY_TIMEOUT sets error_o and sends the block to IDLE (cs_no=1, busy_o=0). No sample or scan_done_o is emitted for that channel.
- start_i while busy_o=1 is ignored. continuous_i is sampled only in the EMIT cycle of the last channel.
- Dropping continuous_i mid-scan lets the current scan finish.

## Timing
- Reset values: sclk_o=0, mosi_o=0, cs_no=1, busy_o=0, sample_valid_o=0, scan_done_o=0, error_o=0, sample_o=0, channel_o=0.
- Reset low at any cycle aborts the transfer. All outputs take their reset values on the next edge.
- start_i → busy_o=1 and cs_no=0 one cycle later.
- Synchronized DRDY lags drdy_ni by 2 cycles. The first SCLK rise occurs in the cycle after MUX_WAIT sees it low.
- Byte time: 16·CLK_DIV cycles. MUX_WR: 5·(16·CLK_DIV+GAP_CYCLES). RDATA: 16·CLK_DIV+T6_CYCLES. READ: 48·CLK_DIV.
- sample_valid_o fires 1 cycle after the 24th falling-edge sample.
- scan_done_o coincides with the last channel's sample_valid_o.
- The timeout counter saturates at DRDY_TIMEOUT; error_o asserts exactly DRDY_TIMEOUT cycles after wait-state entry.

## Test plan
- Single scan, NUM_CH=2, CLK_DIV=4, behavioural ADS1256 model returning 0x123456 (ch0) and 0xFEDCBA (ch1) → two valid pulses with channel 0 then 1 and those values. MOSI decodes 51 00 08 FC 00 01 then 51 00 18 FC 00 01. scan_done_o is high with the second pulse.
- SCLK checks: model asserts sclk_o high/low widths = CLK_DIV cycles, idle low, and ≥GAP_CYCLES between command bytes. It also checks T6_CYCLES between the RDATA end and the first read rise.
- Continuous mode: continuous_i=1 for 3 scans, then drop it → channels 0,1,0,1,0,1, three scan_done_o pulses, then busy_o=0 and cs_no=1.
- DRDY stuck high, DRDY_TIMEOUT=1000 → error_o=1 exactly 1000 cycles after MUX_WAIT entry, busy_o=0, no valid pulse. The next start_i clears error_o.
- Reset low in the middle of the READ of byte 2 → next cycle: sclk_o=0, cs_no=1, busy_o=0. A following start_i runs a clean scan from ch0.
- start_i pulsed while busy → ignored, sequence unchanged. Negative full-scale 0x800000 → sample_o=0x800000 unaltered.

Source files
------------

// File: rtl/ads1256_scan_ctrl_if.sv
// Pin and result bundle between the ADS1256 scan sequencer and its surroundings.
// master = the scan controller, slave = board logic plus the converter pins.
interface ads1256_scan_ctrl_if;
  logic        start_i;
  logic        continuous_i;
  logic        drdy_ni;
  logic        miso_i;
  logic        mosi_o;
  logic        sclk_o;
  logic        cs_no;
  logic [23:0] sample_o;
  logic [2:0]  channel_o;
  logic        sample_valid_o;
  logic        scan_done_o;
  logic        busy_o;
  logic        error_o;

  modport master (
    input  start_i, continuous_i, drdy_ni, miso_i,
    output mosi_o, sclk_o, cs_no, sample_o, channel_o,
           sample_valid_o, scan_done_o, busy_o, error_o
  );

  modport slave (
    output start_i, continuous_i, drdy_ni, miso_i,
    input  mosi_o, sclk_o, cs_no, sample_o, channel_o,
           sample_valid_o, scan_done_o, busy_o, error_o
  );
endinterface

// File: rtl/ads1256_scan_ctrl.sv
// Multi-channel ADS1256 scan sequencer with a built-in SPI mode-1 shift engine.
// Per channel: write MUX, SYNC, WAKEUP, wait for a fresh DRDY, RDATA, read 24 bits.
module ads1256_scan_ctrl #(
  parameter int NUM_CH       = 8,
  parameter int CLK_DIV      = 32,
  parameter int GAP_CYCLES   = 400,
  parameter int T6_CYCLES    = 700,
  parameter int DRDY_TIMEOUT = 2_000_000
) (
  input logic                 clock_i,
  input logic                 reset_ni,
  ads1256_scan_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, MUX_WAIT, MUX_WR, CONV_WAIT, RDATA, READ, EMIT} state_t;

  localparam logic [31:0] HALF_END = 32'(CLK_DIV - 1);
  localparam logic [31:0] GAP_END  = 32'(CLK_DIV + GAP_CYCLES - 1);
  localparam logic [31:0] T6_END   = 32'(CLK_DIV + T6_CYCLES - 1);
  localparam logic [31:0] TO_END   = 32'(DRDY_TIMEOUT - 1);
  localparam logic [7:0]  CMD_WREG = 8'h51;
  localparam logic [7:0]  CMD_RDAT = 8'h01;

  state_t      state;
  logic [1:0]  drdy_sync;
  logic        drdy;
  logic [31:0] tcnt, wcnt;
  logic [2:0]  ch, byte_idx;
  logic [4:0]  bit_idx;
  logic        sclk_hi, conv_hi;
  logic [23:0] shreg;
  logic [7:0]  tx_byte, nxt_byte;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [2:0] c);
    case (idx)
      3'd0:    cmd_byte = CMD_WREG;
      3'd2:    cmd_byte = {1'b0, c, 4'h8};
      3'd3:    cmd_byte = 8'hFC;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign drdy = drdy_sync[1];

  always_comb begin
    tx_byte  = (state == RDATA) ? CMD_RDAT : cmd_byte(byte_idx, ch);
    nxt_byte = cmd_byte(byte_idx + 3'd1, ch);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state              <= IDLE;
      drdy_sync          <= 2'b11;
      tcnt               <= '0;
      wcnt               <= '0;
      ch                 <= '0;
      byte_idx           <= '0;
      bit_idx            <= '0;
      sclk_hi            <= 1'b0;
      conv_hi            <= 1'b0;
      shreg              <= '0;
      bus.sclk_o         <= 1'b0;
      bus.mosi_o         <= 1'b0;
      bus.cs_no          <= 1'b1;
      bus.busy_o         <= 1'b0;
      bus.sample_valid_o <= 1'b0;
      bus.scan_done_o    <= 1'b0;
      bus.error_o        <= 1'b0;
      bus.sample_o       <= '0;
      bus.channel_o      <= '0;
    end else begin
      drdy_sync          <= {drdy_sync[0], bus.drdy_ni};
      bus.sample_valid_o <= 1'b0;
      bus.scan_done_o    <= 1'b0;
      case (state)
        IDLE: if (bus.start_i) begin
          state       <= MUX_WAIT;
          ch          <= '0;
          wcnt        <= '0;
          bus.busy_o  <= 1'b1;
          bus.cs_no   <= 1'b0;
          bus.error_o <= 1'b0;
        end

        MUX_WAIT: begin
          if (!drdy) begin
            // first bit launches on the transition edge
            state      <= MUX_WR;
            byte_idx   <= '0;
            bit_idx    <= '0;
            tcnt       <= '0;
            sclk_hi    <= 1'b1;
            bus.sclk_o <= 1'b1;
            bus.mosi_o <= CMD_WREG[7];
          end else if (wcnt == TO_END) begin
            state       <= IDLE;
            bus.error_o <= 1'b1;
            bus.busy_o  <= 1'b0;
            bus.cs_no   <= 1'b1;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end

        MUX_WR, RDATA: begin
          if (sclk_hi) begin
            if (tcnt == HALF_END) begin
              bus.sclk_o <= 1'b0;
              sclk_hi    <= 1'b0;
              tcnt       <= '0;
            end else tcnt <= tcnt + 32'd1;
          end else if (bit_idx != 5'd7) begin
            if (tcnt == HALF_END) begin
              bus.sclk_o <= 1'b1;
              sclk_hi    <= 1'b1;
              tcnt       <= '0;
              bit_idx    <= bit_idx + 5'd1;
              bus.mosi_o <= tx_byte[3'd6 - bit_idx[2:0]];
            end else tcnt <= tcnt + 32'd1;
          end else if (tcnt == ((state == MUX_WR) ? GAP_END : T6_END)) begin
            // trailing low half plus t11 / t6 have elapsed
            tcnt    <= '0;
            bit_idx <= '0;
            if (state == RDATA) begin
              state      <= READ;
              bus.sclk_o <= 1'b1;
              sclk_hi    <= 1'b1;
              bus.mosi_o <= 1'b0;
            end else if (byte_idx != 3'd4) begin
              byte_idx   <= byte_idx + 3'd1;
              bus.sclk_o <= 1'b1;
              sclk_hi    <= 1'b1;
              bus.mosi_o <= nxt_byte[7];
            end else begin
              state      <= CONV_WAIT;
              conv_hi    <= 1'b0;
              wcnt       <= '0;
              bus.mosi_o <= 1'b0;
            end
          end else tcnt <= tcnt + 32'd1;
        end

        CONV_WAIT: begin
          // only a high-to-low DRDY transition marks the post-SYNC conversion
          if (conv_hi && !drdy) begin
            state      <= RDATA;
            tcnt       <= '0;
            bit_idx    <= '0;
            sclk_hi    <= 1'b1;
            bus.sclk_o <= 1'b1;
            bus.mosi_o <= CMD_RDAT[7];
          end else if (wcnt == TO_END) begin
            state       <= IDLE;
            bus.error_o <= 1'b1;
            bus.busy_o  <= 1'b0;
            bus.cs_no   <= 1'b1;
          end else begin
            wcnt <= wcnt + 32'd1;
            if (drdy) conv_hi <= 1'b1;
          end
        end

        READ: begin
          if (sclk_hi) begin
            if (tcnt == HALF_END) begin
              bus.sclk_o <= 1'b0;
              sclk_hi    <= 1'b0;
              tcnt       <= '0;
              shreg      <= {shreg[22:0], bus.miso_i};
              if (bit_idx == 5'd23) state <= EMIT;
            end else tcnt <= tcnt + 32'd1;
          end else if (tcnt == HALF_END) begin
            bus.sclk_o <= 1'b1;
            sclk_hi    <= 1'b1;
            tcnt       <= '0;
            bit_idx    <= bit_idx + 5'd1;
          end else tcnt <= tcnt + 32'd1;
        end

        EMIT: begin
          bus.sample_o       <= shreg;
          bus.channel_o      <= ch;
          bus.sample_valid_o <= 1'b1;
          wcnt               <= '0;
          if (ch != 3'(NUM_CH - 1)) begin
            ch    <= ch + 3'd1;
            state <= MUX_WAIT;
          end else begin
            bus.scan_done_o <= 1'b1;
            if (bus.continuous_i) begin
              ch    <= '0;
              state <= MUX_WAIT;
            end else begin
              state      <= IDLE;
              bus.busy_o <= 1'b0;
              bus.cs_no  <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ads1256_scan_ctrl.sv
// Bench for ads1256_scan_ctrl: behavioural ADS1256 pin model plus sample/command scoreboard.
module tb_ads1256_scan_ctrl;
  localparam int NUM_CH = 2, CD = 4, GAP = 10, T6 = 12, TO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ads1256_scan_ctrl_if bus();

  ads1256_scan_ctrl #(
    .NUM_CH(NUM_CH), .CLK_DIV(CD), .GAP_CYCLES(GAP), .T6_CYCLES(T6), .DRDY_TIMEOUT(TO)
  ) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]  ch;
    logic [23:0] val;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  logic [23:0] vals[0:7];
  int n_chk = 0, n_fail = 0;

  // converter model state
  int cyc = 0, hi_cnt = 0, lo_cnt = 0, low_kind = 0, bitn = 0, rbit = 0, pos = 0, dcnt = 0;
  int done_cnt = 0, busy_cyc = 0, err_cyc = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_busy = 1'b0, p_err = 1'b0;
  logic cur_bit = 1'b0, in_read = 1'b0, stuck = 1'b0;
  logic [7:0]  shb = '0;
  logic [2:0]  mch = '0;
  logic [23:0] rd_val = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    hi_cnt = 0; lo_cnt = 0; low_kind = 0; bitn = 0; rbit = 0; pos = 0; dcnt = 0;
    in_read = 1'b0; p_sclk = 1'b0; p_cs = 1'b1; p_busy = 1'b0; p_err = 1'b0;
    bus.drdy_ni = stuck;
  endtask

  task automatic tick();
    exp_t e;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      model_rst();
      return;
    end
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) bus.drdy_ni = 1'b0;
    end
    if (stuck) bus.drdy_ni = 1'b1;

    if (bus.sclk_o && !p_sclk) begin
      case (low_kind)
        1: chk("sclk_lo", 32'(lo_cnt), 32'(CD));
        2: chk("cmd_gap", 32'(lo_cnt >= CD + GAP), 32'd1);
        3: chk("t6", 32'(lo_cnt), 32'(CD + T6));
        default: ;
      endcase
      hi_cnt  = 1;
      cur_bit = bus.mosi_o;
      if (in_read) begin
        chk("rd_mosi", 32'(bus.mosi_o), 32'd0);
        bus.miso_i = rd_val[23 - rbit];
      end
    end else if (bus.sclk_o) begin
      hi_cnt++;
    end else if (p_sclk) begin
      chk("sclk_hi", 32'(hi_cnt), 32'(CD));
      lo_cnt = 1;
      if (in_read) begin
        rbit++;
        low_kind = 1;
        if (rbit == 24) begin
          in_read  = 1'b0;
          low_kind = 0;
        end
      end else begin
        shb = {shb[6:0], cur_bit};
        bitn++;
        low_kind = 1;
        if (bitn == 8) begin
          bitn = 0;
          low_kind = 2;
          if (byte_q.size() == 0) chk("mosi_unexp", 32'(shb), 32'hFFFF_FFFF);
          else begin
            b = byte_q.pop_front();
            chk("mosi_byte", 32'(shb), 32'(b));
          end
          if (pos == 2) mch = shb[6:4];
          if (pos == 4) begin
            bus.drdy_ni = 1'b1;
            dcnt = 40;
          end
          if (pos == 5) begin
            in_read  = 1'b1;
            rbit     = 0;
            rd_val   = vals[mch];
            low_kind = 3;
            pos      = 0;
          end else pos++;
        end
      end
    end else begin
      lo_cnt++;
    end
    p_sclk = bus.sclk_o;

    if (bus.cs_no && !p_cs) chk("idle_lo", 32'(bus.sclk_o), 32'd0);
    p_cs = bus.cs_no;

    if (bus.sample_valid_o) begin
      if (exp_q.size() == 0) chk("valid_unexp", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("channel", 32'(bus.channel_o), 32'(e.ch));
        chk("sample", 32'(bus.sample_o), 32'(e.val));
        chk("scan_done", 32'(bus.scan_done_o), 32'(e.done));
      end
    end else if (bus.scan_done_o) chk("done_alone", 32'd1, 32'd0);
    if (bus.scan_done_o) done_cnt++;
    if (bus.busy_o && !p_busy) busy_cyc = cyc;
    if (bus.error_o && !p_err) err_cyc = cyc;
    p_busy = bus.busy_o;
    p_err  = bus.error_o;
  endtask

  task automatic push_scan(input int nscans);
    for (int s = 0; s < nscans; s++)
      for (int c = 0; c < NUM_CH; c++) begin
        byte_q.push_back(8'h51);
        byte_q.push_back(8'h00);
        byte_q.push_back({1'b0, 3'(c), 4'h8});
        byte_q.push_back(8'hFC);
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h01);
        exp_q.push_back('{ch: 3'(c), val: vals[c], done: (c == NUM_CH - 1)});
      end
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && bus.busy_o; i++) tick();
    chk(tag, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic scan_end(input string tag, input int scans);
    chk({tag, "_cs"}, 32'(bus.cs_no), 32'd1);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_bytes"}, 32'(byte_q.size()), 32'd0);
    chk({tag, "_done"}, 32'(done_cnt), 32'(scans));
  endtask

  initial begin
    bus.start_i = 1'b0; bus.continuous_i = 1'b0; bus.drdy_ni = 1'b0; bus.miso_i = 1'b0;
    for (int i = 0; i < 8; i++) vals[i] = '0;
    vals[0] = 24'h123456;
    vals[1] = 24'hFEDCBA;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_sclk", 32'(bus.sclk_o), 32'd0);
    chk("rst_mosi", 32'(bus.mosi_o), 32'd0);
    chk("rst_cs", 32'(bus.cs_no), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid_o), 32'd0);
    chk("rst_done", 32'(bus.scan_done_o), 32'd0);
    chk("rst_err", 32'(bus.error_o), 32'd0);
    chk("rst_sample", 32'(bus.sample_o), 32'd0);
    chk("rst_chan", 32'(bus.channel_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single scan
    done_cnt = 0;
    push_scan(1);
    pulse_start();
    chk("busy_on", 32'(bus.busy_o), 32'd1);
    chk("cs_on", 32'(bus.cs_no), 32'd0);
    wait_idle(5000, "scan1_idle");
    scan_end("scan1", 1);

    // negative full scale, plus a start pulse mid-scan that must be ignored
    vals[1] = 24'h800000;
    done_cnt = 0;
    push_scan(1);
    pulse_start();
    repeat (300) tick();
    pulse_start();
    wait_idle(5000, "nfs_idle");
    scan_end("nfs", 1);
    repeat (50) tick();
    chk("no_restart", 32'(bus.busy_o), 32'd0);

    // continuous mode, three scans
    vals[1] = 24'hFEDCBA;
    done_cnt = 0;
    bus.continuous_i = 1'b1;
    push_scan(3);
    pulse_start();
    for (int i = 0; i < 10000 && done_cnt < 2; i++) tick();
    chk("cont_two", 32'(done_cnt), 32'd2);
    bus.continuous_i = 1'b0;
    wait_idle(5000, "cont_idle");
    scan_end("cont", 3);

    // DRDY stuck high: timeout
    stuck = 1'b1;
    bus.drdy_ni = 1'b1;
    repeat (4) tick();
    done_cnt = 0;
    pulse_start();
    wait_idle(3000, "to_idle");
    chk("to_err", 32'(bus.error_o), 32'd1);
    chk("to_latency", 32'(err_cyc - busy_cyc), 32'(TO));
    chk("to_cs", 32'(bus.cs_no), 32'd1);
    chk("to_done", 32'(done_cnt), 32'd0);
    stuck = 1'b0;
    bus.drdy_ni = 1'b0;
    repeat (4) tick();
    chk("err_sticky", 32'(bus.error_o), 32'd1);
    push_scan(1);
    pulse_start();
    chk("err_clr", 32'(bus.error_o), 32'd0);
    wait_idle(5000, "post_to_idle");
    scan_end("post_to", 1);

    // reset in the middle of the second read byte
    done_cnt = 0;
    push_scan(1);
    pulse_start();
    for (int i = 0; i < 5000 && !(in_read && rbit == 10); i++) tick();
    chk("rd_reached", 32'(in_read), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sclk", 32'(bus.sclk_o), 32'd0);
    chk("mid_rst_cs", 32'(bus.cs_no), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    exp_q.delete();
    byte_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    done_cnt = 0;
    push_scan(1);
    pulse_start();
    wait_idle(5000, "post_rst_idle");
    scan_end("post_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
